// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the unified-memory port arbiter.
//            The arbiter FSM states, the transaction owner tag and the
//            doubleword alignment width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Byte-offset bits inside one 64-bit doubleword.
  localparam int unsigned c_DW_ALIGN_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch port, the data port and the memory macro port
//            of the arbiter.
// Ports    : master - requester/memory side (drives requests and mem_rdata)
//            slave  - arbiter side (drives grants, read data, memory strobes)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // data (ld/sd) port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // memory macro port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_latcnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_latcnt
// Purpose  : Read-latency down-counter. Loaded when a read is issued, counts
//            down once per wait cycle and flags zero when the memory data is
//            due.
// Ports    : CLK        - clock
//            RST        - synchronous active-low reset
//            i_load     - load i_load_val (has priority over i_dec)
//            i_load_val - value to load
//            i_dec      - decrement by one (holds at zero)
//            o_zero     - counter is zero
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_latcnt #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single-port unified memory between instruction fetch
//            and data (ld/sd) accesses. One transaction at a time, data port
//            has priority, and fetch is guaranteed a grant after STARVE_MAX
//            consecutive data grants while it waits. Read data returns with a
//            one-cycle rvalid pulse RD_LAT cycles after the memory strobe.
// Ports    : CLK  - clock
//            RST  - synchronous active-low reset
//            bus  - fetch, data and memory ports (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned c_LAT_W    = $clog2(RD_LAT + 1);
  localparam int unsigned c_STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0]     c_ADDR_MASK  = ~(ADDR_W'((1 << c_DW_ALIGN_W) - 1));
  localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);
  localparam logic [c_LAT_W-1:0]    c_LAT_INIT   = c_LAT_W'(RD_LAT - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  arb_owner_t            r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_STARVE_W-1:0] r_starve;
  logic [31:0]           r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;

  logic                  w_any_req;
  logic                  w_if_win;
  logic                  w_accept;
  logic                  w_lat_load;
  logic                  w_lat_dec;
  logic                  w_lat_zero;
  logic                  w_capture;
  logic                  w_issue;
  logic [31:0]           w_if_word;

  assign w_any_req = bus.if_req | bus.dm_req;
  // Data wins unless fetch has already waited out STARVE_MAX data grants.
  assign w_if_win  = bus.if_req & (~bus.dm_req | (r_starve == c_STARVE_LIM));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_lat_load  = 1'b0;
    w_lat_dec   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_state_nxt = IDLE;
        end else begin
          w_lat_load  = 1'b1;
          w_state_nxt = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (w_lat_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_lat_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  mem_arb_latcnt #(
    .WIDTH (c_LAT_W)
  ) u_latcnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_lat_load),
    .i_load_val (c_LAT_INIT),
    .i_dec      (w_lat_dec),
    .o_zero     (w_lat_zero)
  );

  // --------------------------------------------------------------------------
  // Transaction latch: the winner's request is frozen at acceptance so a
  // requester that misbehaves after acceptance cannot disturb the access.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      if (w_if_win) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_addr  <= bus.if_addr;
        r_wdata <= '0;
      end else begin
        r_owner <= OWN_DM;
        r_we    <= bus.dm_we;
        r_addr  <= bus.dm_addr;
        r_wdata <= bus.dm_wdata;
      end
    end
  end

  // Counts data grants taken while fetch was waiting; only moves in IDLE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (!bus.if_req || w_if_win) begin
        r_starve <= '0;
      end else if (r_starve != c_STARVE_LIM) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return: data is passed through combinationally in the capture cycle
  // so rvalid and rdata line up, then held per port until its next capture.
  // --------------------------------------------------------------------------
  assign w_if_word = r_addr[c_DW_ALIGN_W-1] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner == OWN_IF) begin
        r_if_rdata <= w_if_word;
      end else begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_issue       = (r_state == ISSUE);
  assign bus.mem_en    = w_issue;
  assign bus.mem_we    = w_issue & r_we;
  assign bus.mem_addr  = r_addr & c_ADDR_MASK;
  assign bus.mem_wdata = r_wdata;

  assign bus.if_gnt    = w_issue & (r_owner == OWN_IF);
  assign bus.dm_gnt    = w_issue & (r_owner == OWN_DM);
  assign bus.if_rvalid = w_capture & (r_owner == OWN_IF);
  assign bus.dm_rvalid = w_capture & (r_owner == OWN_DM);

  assign bus.if_rdata  = (w_capture && (r_owner == OWN_IF)) ? w_if_word : r_if_rdata;
  assign bus.dm_rdata  = (w_capture && (r_owner == OWN_DM)) ? bus.mem_rdata : r_dm_rdata;

endmodule
`default_nettype wire
